// File: rtl/map_tile_store_if.sv
// Request/response bundle between the game/display initiators
// and the maze tile store.
interface map_tile_store_if;
  logic [4:0] map_x;
  logic [4:0] map_y;
  logic [2:0] spriteIn;
  logic       readWrite;
  logic       reload;
  logic [2:0] spriteOut;
  logic       ready;
  logic [9:0] pellets_left;
  logic       level_clear;

  modport master (
    output map_x, map_y, spriteIn,
    output readWrite, reload,
    input  spriteOut, ready,
    input  pellets_left, level_clear
  );

  modport slave (
    input  map_x, map_y, spriteIn,
    input  readWrite, reload,
    output spriteOut, ready,
    output pellets_left, level_clear
  );
endinterface

// File: rtl/map_tile_store.sv
// Maze tile store: builds the 32x24 maze, serves tile reads and
// writes, and keeps a running count of pellets left.
module map_tile_store #(
  parameter int MAP_W   = 32,
  parameter int MAP_H   = 24,
  parameter int START_X = 2,
  parameter int START_Y = 1
) (
  input logic clk,
  input logic reset,
  map_tile_store_if.slave bus
);

  localparam int LP_DEPTH = 32 * MAP_H;

  localparam logic [4:0] LP_XMAX = 5'(MAP_W - 1);
  localparam logic [4:0] LP_YMAX = 5'(MAP_H - 1);
  localparam logic [4:0] LP_XPP  = 5'(MAP_W - 2);
  localparam logic [4:0] LP_YPP  = 5'(MAP_H - 2);
  localparam logic [4:0] LP_SX   = 5'(START_X);
  localparam logic [4:0] LP_SY   = 5'(START_Y);

  localparam logic [2:0] T_EMPTY = 3'b000;
  localparam logic [2:0] T_PEL   = 3'b001;
  localparam logic [2:0] T_POW   = 3'b010;
  localparam logic [2:0] T_BLUE  = 3'b011;
  localparam logic [2:0] T_GREY  = 3'b100;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t     r_state, w_state_nx;
  logic [4:0] r_gx, w_gx_nx;
  logic [4:0] r_gy, w_gy_nx;
  logic [9:0] r_cnt, w_cnt_nx;
  logic [2:0] r_out, w_out_nx;

  logic [2:0] r_mem [LP_DEPTH];

  logic [2:0] w_gen;
  logic [9:0] w_raddr;
  logic       w_inr;
  logic [2:0] w_old;
  logic       w_we;
  logic [9:0] w_waddr;
  logic [2:0] w_wdata;
  logic       w_ready;

  function automatic logic is_pel(input logic [2:0] v);
    return (v == T_PEL) || (v == T_POW);
  endfunction

  assign w_raddr = {bus.map_y, bus.map_x};
  assign w_inr   = (bus.map_y <= LP_YMAX);
  assign w_old   = w_inr ? r_mem[w_raddr] : T_GREY;

  // Maze rule for the cell under the build cursor
  always_comb begin
    w_gen = T_PEL;
    if (r_gx == 5'd0 || r_gx == LP_XMAX ||
        r_gy == 5'd0 || r_gy == LP_YMAX)
      w_gen = T_GREY;
    else if ((r_gx == 5'd1 || r_gx == LP_XPP) &&
             (r_gy == 5'd1 || r_gy == LP_YPP))
      w_gen = T_POW;
    else if (r_gx == LP_SX && r_gy == LP_SY)
      w_gen = T_EMPTY;
    else if (r_gx[1:0] == 2'd2 && r_gy[1:0] == 2'd2)
      w_gen = T_BLUE;
  end

  // Next state, build cursor, pellet count and write port
  always_comb begin
    w_state_nx = r_state;
    w_gx_nx    = r_gx;
    w_gy_nx    = r_gy;
    w_cnt_nx   = r_cnt;
    w_out_nx   = T_GREY;
    w_we       = 1'b0;
    w_waddr    = {r_gy, r_gx};
    w_wdata    = w_gen;
    unique case (r_state)
      S_INIT: begin
        w_we = 1'b1;
        if (is_pel(w_gen))
          w_cnt_nx = r_cnt + 10'd1;
        if (r_gx == LP_XMAX) begin
          w_gx_nx = 5'd0;
          if (r_gy == LP_YMAX) begin
            w_gy_nx    = 5'd0;
            w_state_nx = S_RUN;
          end else begin
            w_gy_nx = r_gy + 5'd1;
          end
        end else begin
          w_gx_nx = r_gx + 5'd1;
        end
      end
      S_RUN: begin
        w_out_nx = w_old;
        if (bus.reload) begin
          w_state_nx = S_INIT;
          w_gx_nx    = 5'd0;
          w_gy_nx    = 5'd0;
          w_cnt_nx   = 10'd0;
        end else if (bus.readWrite && w_inr) begin
          w_we    = 1'b1;
          w_waddr = w_raddr;
          w_wdata = bus.spriteIn;
          if (is_pel(w_old) && !is_pel(bus.spriteIn))
            w_cnt_nx = r_cnt - 10'd1;
          else if (!is_pel(w_old) && is_pel(bus.spriteIn))
            w_cnt_nx = r_cnt + 10'd1;
        end
      end
      default: w_state_nx = S_INIT;
    endcase
  end

  // State, cursor, count and read-data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
      r_gx    <= 5'd0;
      r_gy    <= 5'd0;
      r_cnt   <= 10'd0;
      r_out   <= T_GREY;
    end else begin
      r_state <= w_state_nx;
      r_gx    <= w_gx_nx;
      r_gy    <= w_gy_nx;
      r_cnt   <= w_cnt_nx;
      r_out   <= w_out_nx;
    end
  end

  // Tile array write port; reads are asynchronous
  always_ff @(posedge clk) begin
    if (!reset && w_we)
      r_mem[w_waddr] <= w_wdata;
  end

  assign w_ready          = (r_state == S_RUN);
  assign bus.ready        = w_ready;
  assign bus.spriteOut    = r_out;
  assign bus.pellets_left = r_cnt;
  assign bus.level_clear  = w_ready && (r_cnt == 10'd0);

endmodule

// File: tb/tb_map_tile_store.sv
// Bench for map_tile_store: scoreboarded tile reads plus
// direct checks of ready, pellet count and level clear.
module tb_map_tile_store;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  map_tile_store_if bus();

  map_tile_store dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string      tag;
    logic [2:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_vec = 0;
  int  n_bad = 0;

  logic [2:0] mdl [24][32];
  int         mdl_cnt;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_p(input logic [2:0] v);
    return (v == 3'd1) || (v == 3'd2);
  endfunction

  function automatic logic [2:0] gen(input int x, input int y);
    if (x == 0 || x == 31 || y == 0 || y == 23) return 3'd4;
    if ((x == 1 || x == 30) && (y == 1 || y == 22)) return 3'd2;
    if (x == 2 && y == 1) return 3'd0;
    if (x % 4 == 2 && y % 4 == 2) return 3'd3;
    return 3'd1;
  endfunction

  task automatic rebuild();
    mdl_cnt = 0;
    for (int y = 0; y < 24; y++)
      for (int x = 0; x < 32; x++) begin
        mdl[y][x] = gen(x, y);
        if (is_p(mdl[y][x])) mdl_cnt++;
      end
  endtask

  function automatic logic [2:0] mdl_rd(input int x, input int y);
    if (y >= 24) return 3'd4;
    return mdl[y][x];
  endfunction

  task automatic push(input string tag, input logic [2:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic cyc();
    sb_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, 32'(bus.spriteOut), 32'(e.exp));
    end
  endtask

  task automatic rd(input string tag, input int x, input int y,
                    input logic [2:0] exp);
    bus.map_x     = 5'(x);
    bus.map_y     = 5'(y);
    bus.readWrite = 1'b0;
    push(tag, exp);
    cyc();
  endtask

  task automatic wr(input string tag, input int x, input int y,
                    input logic [2:0] v);
    logic [2:0] old;
    old           = mdl_rd(x, y);
    bus.map_x     = 5'(x);
    bus.map_y     = 5'(y);
    bus.spriteIn  = v;
    bus.readWrite = 1'b1;
    push(tag, old);
    if (y < 24) begin
      if (is_p(old) && !is_p(v)) mdl_cnt--;
      else if (!is_p(old) && is_p(v)) mdl_cnt++;
      mdl[y][x] = v;
    end
    cyc();
    bus.readWrite = 1'b0;
    check({tag, "_cnt"}, 32'(bus.pellets_left), 32'(mdl_cnt));
  endtask

  task automatic wait_ready(input string tag, input int reload_at);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 2000) begin
      bus.reload = (n == reload_at);
      push({tag, "_wall"}, 3'd4);
      cyc();
      n++;
    end
    bus.reload = 1'b0;
    check({tag, "_edges"}, 32'(n), 32'd768);
  endtask

  initial begin
    reset         = 1'b1;
    bus.map_x     = '0;
    bus.map_y     = '0;
    bus.spriteIn  = '0;
    bus.readWrite = 1'b0;
    bus.reload    = 1'b0;
    cyc();
    reset = 1'b0;
    check("rst_out", 32'(bus.spriteOut), 32'd4);
    check("rst_rdy", 32'(bus.ready), 32'd0);
    check("rst_cnt", 32'(bus.pellets_left), 32'd0);
    check("rst_clr", 32'(bus.level_clear), 32'd0);

    rebuild();
    wait_ready("build", -1);
    check("build_cnt", 32'(bus.pellets_left), 32'd612);
    check("build_mdl", 32'(bus.pellets_left), 32'(mdl_cnt));
    check("build_clr", 32'(bus.level_clear), 32'd0);

    rd("rd_0_0", 0, 0, 3'd4);
    rd("rd_1_1", 1, 1, 3'd2);
    rd("rd_2_1", 2, 1, 3'd0);
    rd("rd_2_2", 2, 2, 3'd3);
    rd("rd_3_3", 3, 3, 3'd1);
    rd("rd_oor", 5, 30, 3'd4);

    repeat (5) wr("eat", 3, 3, 3'd0);
    check("eat_611", 32'(bus.pellets_left), 32'd611);
    rd("eat_rd", 3, 3, 3'd0);

    wr("rbw", 5, 5, 3'd3);
    rd("rbw_rd", 5, 5, 3'd3);
    check("rbw_610", 32'(bus.pellets_left), 32'd610);

    wr("c5", 6, 5, 3'd5);
    wr("c2", 6, 5, 3'd2);
    rd("c2_rd", 6, 5, 3'd2);

    wr("oor_wr", 4, 25, 3'd0);
    rd("oor_rd", 4, 25, 3'd4);

    check("pre_clr", 32'(bus.level_clear), 32'd0);
    for (int y = 0; y < 24; y++)
      for (int x = 0; x < 32; x++)
        if (is_p(mdl[y][x])) wr("clr", x, y, 3'd0);
    check("clr_cnt", 32'(bus.pellets_left), 32'd0);
    check("clr_flag", 32'(bus.level_clear), 32'd1);

    bus.reload    = 1'b1;
    bus.readWrite = 1'b0;
    push("rl_rd", mdl_rd(int'(bus.map_x), int'(bus.map_y)));
    cyc();
    bus.reload = 1'b0;
    check("rl_rdy", 32'(bus.ready), 32'd0);
    check("rl_clr", 32'(bus.level_clear), 32'd0);
    check("rl_cnt0", 32'(bus.pellets_left), 32'd0);
    rebuild();
    wait_ready("reload", 100);
    check("rl_cnt", 32'(bus.pellets_left), 32'd612);
    check("rl_clr2", 32'(bus.level_clear), 32'd0);
    rd("rl_3_3", 3, 3, 3'd1);
    rd("rl_5_5", 5, 5, 3'd1);

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (400) begin
      push("mid_wall", 3'd4);
      cyc();
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_rdy", 32'(bus.ready), 32'd0);
    check("mid_cnt0", 32'(bus.pellets_left), 32'd0);
    bus.map_x     = 5'd1;
    bus.map_y     = 5'd1;
    bus.spriteIn  = 3'd0;
    bus.readWrite = 1'b1;
    wait_ready("rst2", -1);
    bus.readWrite = 1'b0;
    check("rst2_cnt", 32'(bus.pellets_left), 32'd612);
    rd("rst2_1_1", 1, 1, 3'd2);
    rd("rst2_1_22", 1, 22, 3'd2);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
